// File: rtl/grant_xfer_pkg.sv
// rtl/grant_xfer_pkg.sv - shared state type and default sizing for the grant transfer controller
package grant_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } xfer_state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int LW_DEF      = 4;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - one-hot vector to index encoder with exactly-one and more-than-one flags
module onehot_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          multi
);

    logic seen;

    // OR together the indices of set bits; a second set bit flags multi
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = idx | IW'(i);
            end
        end
        valid = seen & ~multi;
    end

endmodule

// File: rtl/grant_xfer_ctrl.sv
// rtl/grant_xfer_ctrl.sv - grant-driven burst mover onto one device port; XFER_TIMEOUT_EN adds a stall watchdog
module grant_xfer_ctrl
    import grant_xfer_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int LW      = LW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [N_REQ-1:0]         GRANT,
    input  logic [N_REQ*DW-1:0]      REQ_DATA,
    input  logic [N_REQ*LW-1:0]      REQ_LEN,
    input  logic                     DEV_READY,
    output logic                     DEV_VALID,
    output logic [DW-1:0]            DEV_DATA,
    output logic [$clog2(N_REQ)-1:0] DEV_SRC,
    output logic                     ACK,
    output logic                     BUSY,
    output logic                     ERR
);

    localparam int IW = $clog2(N_REQ);

    xfer_state_t   state_q, state_d;
    logic [IW-1:0] src_q, src_d;
    logic [LW-1:0] beat_q, beat_d;
    logic          err_q, err_d;

    logic [IW-1:0] g_idx;
    logic          g_valid;
    logic          g_multi;
    logic          hs;
    logic          last_beat;

`ifdef XFER_TIMEOUT_EN
    localparam int SCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] STALL_MAX = {SCW{1'b1}};
    logic [SCW-1:0] stall_q, stall_d;
`else
    localparam logic [7:0] TIMEOUT_UNUSED = 8'(TIMEOUT);
`endif

    onehot_enc #(
        .N  (N_REQ),
        .IW (IW)
    ) u_grant_enc (
        .vec   (GRANT),
        .idx   (g_idx),
        .valid (g_valid),
        .multi (g_multi)
    );

    // Next-state logic: grant latch in IDLE, beat counting and abort handling in XFER
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        beat_d    = beat_q;
        err_d     = 1'b0;
        hs        = (state_q == XFER) && DEV_READY;
        last_beat = hs && (beat_q == '0);
`ifdef XFER_TIMEOUT_EN
        stall_d   = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (g_valid) begin
                    state_d = XFER;
                    src_d   = g_idx;
                    beat_d  = REQ_LEN[int'(g_idx)*LW +: LW];
`ifdef XFER_TIMEOUT_EN
                    stall_d = '0;
`endif
                end else if (g_multi) begin
                    err_d = 1'b1;
                end
            end
            XFER: begin
                // A non-final handshake still counts even if the grant drops this cycle
                if (hs && (beat_q != '0)) begin
                    beat_d = beat_q - 1'b1;
                end
                if (last_beat) begin
                    state_d = DONE;
                end else if (!GRANT[src_q]) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`ifdef XFER_TIMEOUT_EN
                else if (!DEV_READY) begin
                    if (stall_q >= SCW'(TIMEOUT - 1)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                    if (stall_q != STALL_MAX) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    stall_d = '0;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            src_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
`ifdef XFER_TIMEOUT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
`ifdef XFER_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign DEV_VALID = (state_q == XFER);
    assign DEV_DATA  = (state_q == XFER) ? REQ_DATA[int'(src_q)*DW +: DW] : '0;
    assign DEV_SRC   = src_q;
    assign ACK       = (state_q == DONE);
    assign BUSY      = (state_q == XFER) || (state_q == DONE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// tb/tb_grant_xfer_ctrl.sv - directed self-checking bench for grant_xfer_ctrl
module tb_grant_xfer_ctrl;

    logic        CLK;
    logic        RSTN;
    logic [3:0]  GRANT;
    logic [31:0] REQ_DATA;
    logic [15:0] REQ_LEN;
    logic        DEV_READY;
    logic        DEV_VALID;
    logic [7:0]  DEV_DATA;
    logic [1:0]  DEV_SRC;
    logic        ACK;
    logic        BUSY;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    grant_xfer_ctrl #(
        .N_REQ   (4),
        .DW      (8),
        .LW      (4),
        .TIMEOUT (15)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .GRANT     (GRANT),
        .REQ_DATA  (REQ_DATA),
        .REQ_LEN   (REQ_LEN),
        .DEV_READY (DEV_READY),
        .DEV_VALID (DEV_VALID),
        .DEV_DATA  (DEV_DATA),
        .DEV_SRC   (DEV_SRC),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] s, input logic a, input logic b, input logic e);
        chk({tag, ".valid"}, {31'd0, DEV_VALID}, {31'd0, v});
        chk({tag, ".data"},  {24'd0, DEV_DATA},  {24'd0, d});
        chk({tag, ".src"},   {30'd0, DEV_SRC},   {30'd0, s});
        chk({tag, ".ack"},   {31'd0, ACK},       {31'd0, a});
        chk({tag, ".busy"},  {31'd0, BUSY},      {31'd0, b});
        chk({tag, ".err"},   {31'd0, ERR},       {31'd0, e});
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RSTN      = 1'b0;
        GRANT     = 4'b0000;
        REQ_DATA  = 32'd0;
        REQ_LEN   = 16'd0;
        DEV_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk_out("reset", 0, 8'h00, 2'd0, 0, 0, 0);
        RSTN = 1'b1;
        step();
        chk_out("idle_after_reset", 0, 8'h00, 2'd0, 0, 0, 0);

        // Requester 1, three beats of 0xA5 with device always ready
        GRANT          = 4'b0010;
        REQ_LEN[7:4]   = 4'd2;
        REQ_DATA[15:8] = 8'hA5;
        DEV_READY      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("r1_beat%0d", i), 1, 8'hA5, 2'd1, 0, 1, 0);
        end
        step();
        chk_out("r1_done", 0, 8'h00, 2'd1, 1, 1, 0);
        GRANT = 4'b0000;
        step();
        chk_out("r1_idle", 0, 8'h00, 2'd1, 0, 0, 0);

        // Requester 0, two beats with ready toggling 0,1,0,1
        GRANT         = 4'b0001;
        REQ_LEN[3:0]  = 4'd1;
        REQ_DATA[7:0] = 8'h3C;
        DEV_READY     = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            DEV_READY = (i % 2 == 1);
            chk_out($sformatf("r0_cyc%0d", i), 1, 8'h3C, 2'd0, 0, 1, 0);
            step();
        end
        chk_out("r0_done", 0, 8'h00, 2'd0, 1, 1, 0);
        GRANT     = 4'b0000;
        DEV_READY = 1'b0;
        step();
        chk_out("r0_idle", 0, 8'h00, 2'd0, 0, 0, 0);

        // Multi-bit grant in IDLE
        GRANT = 4'b0110;
        step();
        chk_out("multi_err", 0, 8'h00, 2'd0, 0, 0, 1);
        GRANT = 4'b0000;
        step();
        chk_out("multi_clear", 0, 8'h00, 2'd0, 0, 0, 0);

        // Requester 3, grant lost after first handshake
        GRANT            = 4'b1000;
        REQ_LEN[15:12]   = 4'd3;
        REQ_DATA[31:24]  = 8'h5A;
        DEV_READY        = 1'b1;
        step();
        chk_out("r3_beat0", 1, 8'h5A, 2'd3, 0, 1, 0);
        step();
        chk_out("r3_beat1", 1, 8'h5A, 2'd3, 0, 1, 0);
        GRANT     = 4'b0000;
        DEV_READY = 1'b0;
        step();
        chk_out("r3_abort", 0, 8'h00, 2'd3, 0, 0, 1);
        step();
        chk_out("r3_after", 0, 8'h00, 2'd3, 0, 0, 0);

        // Requester 2, single beat, device stalled for 15 cycles
        GRANT            = 4'b0100;
        REQ_LEN[11:8]    = 4'd0;
        REQ_DATA[23:16]  = 8'h77;
        DEV_READY        = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            chk_out($sformatf("stall%0d", i), 1, 8'h77, 2'd2, 0, 1, 0);
            step();
        end
`ifdef XFER_TIMEOUT_EN
        chk_out("timeout_done", 0, 8'h00, 2'd2, 1, 1, 1);
        GRANT = 4'b0000;
        step();
        chk_out("timeout_idle", 0, 8'h00, 2'd2, 0, 0, 0);
`else
        chk_out("stall_hold", 1, 8'h77, 2'd2, 0, 1, 0);
        DEV_READY = 1'b1;
        step();
        chk_out("stall_done", 0, 8'h00, 2'd2, 1, 1, 0);
        GRANT     = 4'b0000;
        DEV_READY = 1'b0;
        step();
        chk_out("stall_idle", 0, 8'h00, 2'd2, 0, 0, 0);
`endif

        // Asynchronous reset mid-burst, then a fresh grant
        GRANT        = 4'b0010;
        REQ_LEN[7:4] = 4'd2;
        DEV_READY    = 1'b1;
        step();
        step();
        chk_out("rst_pre", 1, 8'hA5, 2'd1, 0, 1, 0);
        #2;
        RSTN = 1'b0;
        #1;
        chk_out("rst_async", 0, 8'h00, 2'd0, 0, 0, 0);
        GRANT = 4'b0000;
        step();
        chk_out("rst_hold", 0, 8'h00, 2'd0, 0, 0, 0);
        RSTN = 1'b1;
        step();
        chk_out("rst_release", 0, 8'h00, 2'd0, 0, 0, 0);
        GRANT        = 4'b0001;
        REQ_LEN[3:0] = 4'd0;
        step();
        chk_out("post_rst_beat", 1, 8'h3C, 2'd0, 0, 1, 0);
        step();
        chk_out("post_rst_done", 0, 8'h00, 2'd0, 1, 1, 0);
        GRANT = 4'b0000;
        step();
        chk_out("post_rst_idle", 0, 8'h00, 2'd0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
